// File: rtl/id_stage.sv
// Decode stage: register file, control decode, hazard detection and
// jump resolution. It launches the registered ID/EX bundle.
// Ports: clk/rst, if_id {pc+4,instr}, branch_taken, WB write port,
//   MEM writer info in; fetch enable, J/JR selects and targets, ID/EX
//   bundle and stall_count out.
module id_stage #(
  parameter logic [31:0] RESET_PC_PLUS4 = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] if_id,
  input  logic        branch_taken,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  ex_mem_dst,
  output logic        pc_if_id_write,
  output logic        sel_j,
  output logic        sel_jr,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target,
  output logic        id_ex_valid,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_alu_src_imm,
  output logic        id_ex_link,
  output logic [31:0] id_ex_pc_plus4,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [5:0]  id_ex_opcode,
  output logic [5:0]  id_ex_funct,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_dst,
  output logic [31:0] stall_count
);

  logic [31:0] instr;
  logic [31:0] pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign pc4    = if_id[63:32];
  assign instr  = if_id[31:0];
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  // Register file
  logic [31:0] rf_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // Write-through so WB and ID can share a cycle without forwarding.
  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (wb_we && wb_addr == rs) rs_val = wb_data;
    if (wb_we && wb_addr == rt) rt_val = wb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  // Decode
  logic       dec_rw;
  logic       dec_mr;
  logic       dec_mw;
  logic       dec_ais;
  logic       dec_link;
  logic [4:0] dec_dst;
  logic       use_rs;
  logic       use_rt;
  logic       zext;
  logic       is_j;
  logic       is_jr;

  always_comb begin
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_ais  = 1'b0;
    dec_link = 1'b0;
    dec_dst  = 5'd0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    zext     = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    case (opcode)
      6'h00: begin
        dec_rw  = 1'b1;
        dec_dst = rd;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        if (funct == 6'h08) begin
          dec_rw = 1'b0;
          is_jr  = 1'b1;
        end
        if (funct == 6'h09) begin
          dec_link = 1'b1;
          is_jr    = 1'b1;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_rw  = 1'b1;
        dec_ais = 1'b1;
        dec_dst = rt;
        use_rs  = 1'b1;
        zext    = (opcode == 6'h0C) || (opcode == 6'h0D)
               || (opcode == 6'h0E);
      end
      6'h23: begin
        dec_mr  = 1'b1;
        dec_rw  = 1'b1;
        dec_ais = 1'b1;
        dec_dst = rt;
        use_rs  = 1'b1;
      end
      6'h2B: begin
        dec_mw  = 1'b1;
        dec_ais = 1'b1;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
      end
      6'h04, 6'h05: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'h02: is_j = 1'b1;
      6'h03: begin
        is_j     = 1'b1;
        dec_rw   = 1'b1;
        dec_link = 1'b1;
        dec_dst  = 5'd31;
      end
      default: ;
    endcase
  end

  logic [31:0] imm_ext;
  assign imm_ext = zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};

  // Hazards
  logic lu_hz;
  logic jr_hz;
  logic stall;

  always_comb begin
    lu_hz = id_ex_mem_read && id_ex_dst != 5'd0 &&
            ((use_rs && rs == id_ex_dst) ||
             (use_rt && rt == id_ex_dst));
    jr_hz = is_jr && rs != 5'd0 &&
            ((id_ex_reg_write && rs == id_ex_dst) ||
             (ex_mem_reg_write && rs == ex_mem_dst));
  end

  assign stall          = (lu_hz || jr_hz) && !branch_taken;
  assign pc_if_id_write = !stall;
  assign sel_j          = is_j && !stall && !branch_taken;
  assign sel_jr         = is_jr && !stall && !branch_taken;
  assign jump_target    = {pc4[31:28], instr[25:0], 2'b00};
  assign jr_target      = rs_val;

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid       <= 1'b0;
      id_ex_reg_write   <= 1'b0;
      id_ex_mem_read    <= 1'b0;
      id_ex_mem_write   <= 1'b0;
      id_ex_alu_src_imm <= 1'b0;
      id_ex_link        <= 1'b0;
      id_ex_pc_plus4    <= RESET_PC_PLUS4;
      id_ex_rs_data     <= '0;
      id_ex_rt_data     <= '0;
      id_ex_imm         <= '0;
      id_ex_opcode      <= '0;
      id_ex_funct       <= '0;
      id_ex_rs          <= '0;
      id_ex_rt          <= '0;
      id_ex_dst         <= '0;
    end else if (branch_taken || stall) begin
      id_ex_valid       <= 1'b0;
      id_ex_reg_write   <= 1'b0;
      id_ex_mem_read    <= 1'b0;
      id_ex_mem_write   <= 1'b0;
      id_ex_alu_src_imm <= 1'b0;
      id_ex_link        <= 1'b0;
    end else begin
      id_ex_valid       <= (if_id != 64'd0);
      id_ex_reg_write   <= dec_rw;
      id_ex_mem_read    <= dec_mr;
      id_ex_mem_write   <= dec_mw;
      id_ex_alu_src_imm <= dec_ais;
      id_ex_link        <= dec_link;
      id_ex_pc_plus4    <= pc4;
      id_ex_rs_data     <= rs_val;
      id_ex_rt_data     <= rt_val;
      id_ex_imm         <= imm_ext;
      id_ex_opcode      <= opcode;
      id_ex_funct       <= funct;
      id_ex_rs          <= rs;
      id_ex_rt          <= rt;
      id_ex_dst         <= dec_dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: regfile, decode, hazards, jumps, reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_id;
  logic        branch_taken;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_dst;
  logic        pc_if_id_write;
  logic        sel_j;
  logic        sel_jr;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        id_ex_valid;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_alu_src_imm;
  logic        id_ex_link;
  logic [31:0] id_ex_pc_plus4;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [5:0]  id_ex_opcode;
  logic [5:0]  id_ex_funct;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_dst;
  logic [31:0] stall_count;

  int total = 0;
  int bad = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_id(if_id),
    .branch_taken(branch_taken),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_dst(ex_mem_dst),
    .pc_if_id_write(pc_if_id_write),
    .sel_j(sel_j), .sel_jr(sel_jr),
    .jump_target(jump_target), .jr_target(jr_target),
    .id_ex_valid(id_ex_valid),
    .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write),
    .id_ex_alu_src_imm(id_ex_alu_src_imm),
    .id_ex_link(id_ex_link),
    .id_ex_pc_plus4(id_ex_pc_plus4),
    .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm),
    .id_ex_opcode(id_ex_opcode), .id_ex_funct(id_ex_funct),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_dst(id_ex_dst),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_id = '0;
    branch_taken = 1'b0;
    wb_we = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    ex_mem_reg_write = 1'b0;
    ex_mem_dst = '0;
    #3;
    chk("rst_valid", 32'(id_ex_valid), 32'd0);
    chk("rst_rw", 32'(id_ex_reg_write), 32'd0);
    chk("rst_pc4", id_ex_pc_plus4, 32'h8000_0004);
    chk("rst_scnt", stall_count, 32'd0);
    chk("rst_pcw", 32'(pc_if_id_write), 32'd1);
    rst = 1'b0;
    tick();

    // $5 written by WB in the same cycle add $3,$5,$0 reads it
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    if_id = {32'h8000_0008, 32'h00A0_1820};
    #1;
    chk("wt_read", jr_target, 32'h1234);
    tick();
    wb_we = 1'b0;
    chk("add_valid", 32'(id_ex_valid), 32'd1);
    chk("add_rsd", id_ex_rs_data, 32'h1234);
    chk("add_dst", 32'(id_ex_dst), 32'd3);
    chk("add_rw", 32'(id_ex_reg_write), 32'd1);
    chk("add_pc4", id_ex_pc_plus4, 32'h8000_0008);
    tick();
    chk("rf_read", id_ex_rs_data, 32'h1234);

    // lw $2,0($1) ; add $4,$2,$2
    if_id = {32'h8000_000C, 32'h8C22_0000};
    #1;
    chk("lw_pcw", 32'(pc_if_id_write), 32'd1);
    tick();
    chk("lw_mr", 32'(id_ex_mem_read), 32'd1);
    chk("lw_dst", 32'(id_ex_dst), 32'd2);
    if_id = {32'h8000_0010, 32'h0042_2020};
    #1;
    chk("lu_stall", 32'(pc_if_id_write), 32'd0);
    tick();
    chk("lu_bub", 32'(id_ex_valid), 32'd0);
    chk("lu_bub_rw", 32'(id_ex_reg_write), 32'd0);
    chk("lu_scnt", stall_count, 32'd1);
    chk("lu_pcw", 32'(pc_if_id_write), 32'd1);
    tick();
    chk("lu_add_v", 32'(id_ex_valid), 32'd1);
    chk("lu_add_dst", 32'(id_ex_dst), 32'd4);
    chk("lu_scnt2", stall_count, 32'd1);

    // j 0x10 and its branch_taken override
    if_id = {32'h8000_0008, 32'h0800_0010};
    #1;
    chk("j_tgt", jump_target, 32'h8000_0040);
    chk("j_sel", 32'(sel_j), 32'd1);
    chk("j_seljr", 32'(sel_jr), 32'd0);
    branch_taken = 1'b1;
    #1;
    chk("j_bt_sel", 32'(sel_j), 32'd0);
    chk("j_bt_pcw", 32'(pc_if_id_write), 32'd1);
    tick();
    branch_taken = 1'b0;
    chk("j_bt_bub", 32'(id_ex_valid), 32'd0);

    // addi $31,$0,5 then jr $31
    if_id = {32'h8000_0020, 32'h201F_0005};
    tick();
    chk("addi_dst", 32'(id_ex_dst), 32'd31);
    chk("addi_imm", id_ex_imm, 32'd5);
    chk("addi_ais", 32'(id_ex_alu_src_imm), 32'd1);
    if_id = {32'h8000_0024, 32'h03E0_0008};
    #1;
    chk("jr_st1", 32'(pc_if_id_write), 32'd0);
    chk("jr_sel1", 32'(sel_jr), 32'd0);
    tick();
    ex_mem_reg_write = 1'b1; ex_mem_dst = 5'd31;
    #1;
    chk("jr_st2", 32'(pc_if_id_write), 32'd0);
    chk("jr_bub", 32'(id_ex_valid), 32'd0);
    tick();
    ex_mem_reg_write = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd31; wb_data = 32'h8000_1230;
    #1;
    chk("jr_go", 32'(pc_if_id_write), 32'd1);
    chk("jr_sel", 32'(sel_jr), 32'd1);
    chk("jr_selj", 32'(sel_j), 32'd0);
    chk("jr_tgt", jr_target, 32'h8000_1230);
    chk("jr_scnt", stall_count, 32'd3);
    tick();
    wb_we = 1'b0;
    chk("jr_issue", 32'(id_ex_valid), 32'd1);
    chk("jr_rw", 32'(id_ex_reg_write), 32'd0);
    chk("jr_funct", 32'(id_ex_funct), 32'h08);
    chk("jr_scnt2", stall_count, 32'd3);

    // bubble input
    if_id = '0;
    #1;
    chk("zero_pcw", 32'(pc_if_id_write), 32'd1);
    tick();
    chk("zero_v", 32'(id_ex_valid), 32'd0);

    // undefined opcode 3F
    if_id = {32'h8000_0030, 32'hFC22_1234};
    tick();
    chk("op3f_v", 32'(id_ex_valid), 32'd1);
    chk("op3f_ctl", {26'd0, id_ex_reg_write, id_ex_mem_read,
        id_ex_mem_write, id_ex_alu_src_imm, id_ex_link, 1'b0}, 32'd0);

    // immediate extension
    if_id = {32'h8000_0034, 32'h3422_F000};
    tick();
    chk("ori_zext", id_ex_imm, 32'h0000_F000);
    if_id = {32'h8000_0038, 32'h2022_F000};
    tick();
    chk("addi_sext", id_ex_imm, 32'hFFFF_F000);

    // jal
    if_id = {32'h9000_0010, 32'h0C00_0004};
    #1;
    chk("jal_tgt", jump_target, 32'h9000_0010);
    chk("jal_sel", 32'(sel_j), 32'd1);
    tick();
    chk("jal_ctl", {29'd0, id_ex_reg_write, id_ex_link, 1'b0},
        32'd6);
    chk("jal_dst", 32'(id_ex_dst), 32'd31);

    // sw uses rt; follows lw $2
    if_id = {32'h8000_0040, 32'h8C22_0000};
    tick();
    if_id = {32'h8000_0044, 32'hAC22_0004};
    #1;
    chk("sw_stall", 32'(pc_if_id_write), 32'd0);

    // asynchronous reset in the middle of the stall
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(id_ex_valid), 32'd0);
    chk("mrst_mr", 32'(id_ex_mem_read), 32'd0);
    chk("mrst_pc4", id_ex_pc_plus4, 32'h8000_0004);
    chk("mrst_scnt", stall_count, 32'd0);
    chk("mrst_pcw", 32'(pc_if_id_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage pipelined CPU. It consumes the 64-bit IF/ID register `{PC+4, instruction}` and owns the 32×32 register file. It resolves `j`/`jal`/`jr`/`jalr` targets back to the fetch stage, detects load-use and jr-operand hazards, and launches the registered ID/EX bundle. It also drives the fetch stage's write-enable and the J/JR bits of `select_PC_next`; the EX stage drives Z.

## Interface
- `RESET_PC_PLUS4`, `32'h8000_0004`, value of `id_ex_pc_plus4` after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `if_id`  in  64  `[63:32]` = PC+4, `[31:0]` = instruction; all-zero is a bubble.
- `branch_taken`  in  1  Z from EX; the instruction currently in ID is wrong-path.
- `wb_we`, `wb_addr[4:0]`, `wb_data[31:0]`  in  register-file write port from WB.
- `ex_mem_reg_write`  in  1  writer flag of the instruction in MEM.
- `ex_mem_dst`  in  5  destination register of the instruction in MEM.
- `pc_if_id_write`  out  1  fetch-stage enable; 0 = hold PC and IF/ID.
- `sel_j`, `sel_jr`  out  1 each  J and JR bits of `select_PC_next`.
- `jump_target`, `jr_target`  out  32  redirect targets.
- `id_ex_valid`, `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write`, `id_ex_alu_src_imm`, `id_ex_link`  out  1 each.
- `id_ex_pc_plus4`, `id_ex_rs_data`, `id_ex_rt_data`, `id_ex_imm`  out  32 each.
- `id_ex_opcode`, `id_ex_funct`  out  6 each.
- `id_ex_rs`, `id_ex_rt`, `id_ex_dst`  out  5 each.
- `stall_count`  out  32  saturating count of stall cycles.

## Operation
- Register file: 32×32 registers written on the clock edge when `wb_we` is 1 and `wb_addr` ≠ 0. Register `$0` always reads 0. Reads are combinational with write-through: when `wb_we` is 1 and `wb_addr` equals a nonzero read address, the read returns `wb_data`.
- Decode rules (opcode → controls):
  - op 00, R-type: `reg_write`=1, `dst`=rd.
    - funct 08 (`jr`): `reg_write`=0.
    - funct 09 (`jalr`): `link`=1.
  - op 08/09/0A/0B/0C/0D/0E/0F: `reg_write`=1, `alu_src_imm`=1, `dst`=rt. Immediate is zero-extended for 0C/0D/0E and sign-extended otherwise.
  - op 23 (`lw`): `mem_read`, `reg_write`, `alu_src_imm` all 1; `dst`=rt.
  - op 2B (`sw`): `mem_write`=1, `alu_src_imm`=1.
  - op 04/05: no controls set; EX evaluates the branch.
  - op 02 (`j`): jump only.
  - op 03 (`jal`): `reg_write`=1, `link`=1, `dst`=31.
  - Any other opcode: all controls 0 (decoded as a NOP).
- Source usage:
  - R-type uses rs and rt.
  - I-type uses rs; 2B/04/05 also use rt.
  - 02/03 use neither.
  - Register 0 never causes a hazard.
- Load-use stall: `id_ex_mem_read` is 1 and `id_ex_dst` matches a used source.
- jr stall: `jr`/`jalr` whose rs matches `id_ex_dst` (with `id_ex_reg_write`), or matches `ex_mem_dst` (with `ex_mem_reg_write`).
- `stall` = load-use OR jr stall, gated off when `branch_taken` is 1.
- `jump_target` = `{if_id[63:60], instr[25:0], 2'b00}`.
- `jr_target` = bypassed rs read data.
- `sel_j` = (op 02/03) & ~stall & ~`branch_taken`.
- `sel_jr` = (`jr`/`jalr`) & ~stall & ~`branch_taken`.
- `pc_if_id_write` = ~stall.
- ID/EX update each edge:
  - If `branch_taken` or `stall`: load a bubble (all control bits and `id_ex_valid` = 0; data fields don't care, held).
  - Otherwise: load the decoded instruction with `id_ex_valid` = (`if_id` ≠ 0).
- `stall_count` increments on every edge where `stall` is 1 and saturates at `32'hFFFF_FFFF`.

## Timing
- `pc_if_id_write`, `sel_j`, `sel_jr`, and both targets are combinational from `if_id`, ID/EX state, and the MEM inputs, so IF redirects on the next edge. ID/EX has one-cycle latency.
- Reset (asynchronous, any time, including mid-stall):
  - All registers clear to 0.
  - All `id_ex_*` outputs are 0, except `id_ex_pc_plus4` = `RESET_PC_PLUS4`.
  - `stall_count` = 0.
- A load-use stall lasts exactly 1 cycle. A jr stall lasts 1–2 cycles (hazard in ID/EX, then in MEM).
- `branch_taken` overrides everything in the same cycle: no stall, no J/JR asserted, bubble into ID/EX. `sel_j` and `sel_jr` are never both 1.
- A WB write and a same-cycle read of the same register returns the new value.

## Test plan
- Reset with `rst`=1 mid-stream → all `id_ex_*` = 0, `id_ex_pc_plus4` = `32'h8000_0004`, `stall_count` = 0, `pc_if_id_write` = 1.
- Write `$5` = `32'h1234` through WB, then issue `add $3,$5,$0` (instr `32'h00A01820`) → next edge `id_ex_rs_data` = `32'h1234`, `dst` = 3, `reg_write` = 1. A same-cycle write and read also returns `32'h1234`.
- `lw $2,0($1)` followed by `add $4,$2,$2` → 1 cycle with `pc_if_id_write` = 0 and a bubble in ID/EX, then the `add` issues; `stall_count` = 1.
- `j` with instr `32'h0800_0010` at PC+4 `32'h8000_0008` → `jump_target` = `32'h8000_0040`, `sel_j` = 1. The same input with `branch_taken` = 1 → `sel_j` = 0 and a bubble.
- `jr $31` with `$31` being written by the instruction in ID/EX → 2 stall cycles, then `sel_jr` = 1 and `jr_target` = the forwarded WB value.
- `if_id` = 0 → `id_ex_valid` = 0, no stall. An undefined opcode 3F → all controls 0.
